tdm_demux2: RTL and testbench

Two-channel time-division demultiplexer: the receive end of a link where a 2-to-1 mux alternately drives channel 0 and channel 1 words onto one serial wire. It finds the frame start from a sync pulse, shifts WIDTH bits for channel 0 and then WIDTH bits for channel 1, and presents both words in parallel with a one-cycle valid strobe. It sits between the serial link and the parallel consumers of the two channels.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_demux2_sipo.sv | 21 ++
 rtl/tdm_demux2.sv | 127 ++++++++++++
 tb/tb_tdm_demux2.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-channel TDM receiver.
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2,
        PAR  = 2'd3
    } tdm_state_e;

    localparam int TDM_WIDTH = 8;

    // Even parity over the two channel words: the parity bit equals this XOR.
    function automatic logic frame_parity(input logic [TDM_WIDTH-1:0] w0,
                                          input logic [TDM_WIDTH-1:0] w1);
        return (^w0) ^ (^w1);
    endfunction

endpackage

// File: rtl/tdm_demux2_sipo.sv
// Serial-in/parallel-out shift register, MSB first, with shift enable and
// synchronous clear. One instance per channel.
module tdm_sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], d};
        end
    end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: sync-aligned frame of ch0 then ch1 words.
// Optional trailing even-parity bit when TDM_DEMUX2_PARITY_EN is defined.
//
// Handshake: valid is a one-cycle strobe with no back-pressure; ch0_q/ch1_q
// change only in the cycle valid is high and hold until the next strobe.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             sync,
    output logic [WIDTH-1:0] ch0_q,
    output logic [WIDTH-1:0] ch1_q,
    output logic             valid,
    output logic             err,
    output logic [1:0]       fsm_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    tdm_state_e      state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic            en0;
    logic            en1;

    // Any sync (re)starts a frame, so its bit always lands in the ch0 shifter.
    assign en0 = sync | (state == CH0);
    assign en1 = (state == CH1) & ~sync;
    assign fsm_state = state;

    tdm_sipo #(.WIDTH(WIDTH)) u_sipo0 (
        .clk (clk),
        .clr (reset),
        .en  (en0),
        .d   (d),
        .q   (sh0)
    );

    tdm_sipo #(.WIDTH(WIDTH)) u_sipo1 (
        .clk (clk),
        .clr (reset),
        .en  (en1),
        .d   (d),
        .q   (sh1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ch0_q <= '0;
            ch1_q <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= CH0;
                        cnt   <= ONE;
                    end
                end
                CH0: begin
                    if (sync) begin
                        err <= 1'b1;
                        cnt <= ONE;
                    end else if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= CH1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                CH1: begin
                    if (sync) begin
                        err   <= 1'b1;
                        cnt   <= ONE;
                        state <= CH0;
                    end else if (cnt == LAST) begin
                        cnt <= '0;
`ifdef TDM_DEMUX2_PARITY_EN
                        state <= PAR;
`else
                        ch0_q <= sh0;
                        ch1_q <= {sh1[WIDTH-2:0], d};
                        valid <= 1'b1;
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`ifdef TDM_DEMUX2_PARITY_EN
                PAR: begin
                    if (sync) begin
                        err   <= 1'b1;
                        cnt   <= ONE;
                        state <= CH0;
                    end else if (((^sh0) ^ (^sh1)) != d) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ch0_q <= sh0;
                        ch1_q <= sh1;
                        valid <= 1'b1;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// Self-checking bench for tdm_demux2 (default build or TDM_DEMUX2_PARITY_EN).
module tb_tdm_demux2;

    localparam int W = 8;
`ifdef TDM_DEMUX2_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int L = 2 * W + PB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         d = 1'b1;
    logic         sync = 1'b1;
    logic [W-1:0] ch0_q;
    logic [W-1:0] ch1_q;
    logic         valid;
    logic         err;
    logic [1:0]   fsm_state;

    tdm_demux2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .sync      (sync),
        .ch0_q     (ch0_q),
        .ch1_q     (ch1_q),
        .valid     (valid),
        .err       (err),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    int           valid_cyc[$];
    logic [2*W-1:0] valid_dat[$];
    int           err_cyc[$];
    logic [2*W-1:0] err_dat[$];
    logic [2*W-1:0] exp_q[$];
    int           start_q[$];
    int           both_high = 0;

    typedef struct {
        logic [W-1:0] in0;
        logic [W-1:0] in1;
        logic         par;
        logic [W-1:0] exp0;
        logic [W-1:0] exp1;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Outputs observed at the negedge belong to cycle cyc_n; inputs driven
    // here are captured at the rising edge that ends cycle cyc_n.
    task automatic cyc(input logic dv, input logic sv, input logic rv);
        @(negedge clk);
        if (valid) begin
            valid_cyc.push_back(cyc_n);
            valid_dat.push_back({ch0_q, ch1_q});
        end
        if (err) begin
            err_cyc.push_back(cyc_n);
            err_dat.push_back({ch0_q, ch1_q});
        end
        if (valid && err) both_high++;
        d     = dv;
        sync  = sv;
        reset = rv;
        cyc_n++;
    endtask

    task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic p);
        for (int i = 0; i < W; i++) cyc(w0[W-1-i], (i == 0), 1'b0);
        for (int i = 0; i < W; i++) cyc(w1[W-1-i], 1'b0, 1'b0);
        if (PB == 1) cyc(p, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        valid_cyc.delete();
        valid_dat.delete();
        err_cyc.delete();
        err_dat.delete();
    endtask

    initial begin
        int t0;
        int t1;
        logic [W-1:0] w0;
        logic [W-1:0] w1;

        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 1'b0, 8'h00, 8'hFF};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h80, 8'h01};
        vecs[3] = '{8'h55, 8'hAA, 1'b0, 8'h55, 8'hAA};
        vecs[4] = '{8'h12, 8'h34, 1'b1, 8'h12, 8'h34};
        vecs[5] = '{8'h07, 8'h00, 1'b1, 8'h07, 8'h00};

        // Reset held two cycles with d=1, sync=1.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check("reset_ch0", 32'(ch0_q), 32'h0);
        check("reset_ch1", 32'(ch1_q), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_state", 32'(fsm_state), 32'h0);
        clear_logs();
        for (int i = 0; i < 2 * W + 3; i++) cyc(1'b1, 1'b0, 1'b0);
        check("idle_no_valid", 32'(valid_cyc.size()), 32'h0);
        check("idle_state", 32'(fsm_state), 32'h0);

        // Table of single frames separated by two idle cycles.
        clear_logs();
        foreach (vecs[k]) begin
            exp_q.push_back({vecs[k].exp0, vecs[k].exp1});
            start_q.push_back(cyc_n);
            send_frame(vecs[k].in0, vecs[k].in1, vecs[k].par);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("table_valid_count", 32'(valid_cyc.size()), 32'd6);
        check("table_err_count", 32'(err_cyc.size()), 32'd0);
        for (int k = 0; k < 6 && k < valid_cyc.size(); k++) begin
            check($sformatf("table_latency_%0d", k), 32'(valid_cyc[k]), 32'(start_q[k] + L));
            check($sformatf("table_data_%0d", k), 32'(valid_dat[k]), 32'(exp_q.pop_front()));
        end
        check("table_hold_ch0", 32'(ch0_q), 32'h07);
        check("table_hold_ch1", 32'(ch1_q), 32'h00);

        // Back-to-back frames, second sync right after the first frame.
        clear_logs();
        t0 = cyc_n;
        send_frame(8'h01, 8'h02, 1'b0);
        send_frame(8'hFF, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("b2b_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() == 2) begin
            check("b2b_cyc0", 32'(valid_cyc[0]), 32'(t0 + L));
            check("b2b_cyc1", 32'(valid_cyc[1]), 32'(t0 + 2 * L));
            check("b2b_dat0", 32'(valid_dat[0]), 32'h0102);
            check("b2b_dat1", 32'(valid_dat[1]), 32'hFF00);
        end
        check("b2b_err", 32'(err_cyc.size()), 32'd0);

        // Good frame, then a new frame re-synced at ch1 bit 3.
        send_frame(8'hA5, 8'h3C, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        clear_logs();
        t0 = cyc_n;
        w0 = 8'h11;
        w1 = 8'h22;
        for (int i = 0; i < W; i++) cyc(w0[W-1-i], (i == 0), 1'b0);
        for (int i = 0; i < 3; i++) cyc(w1[W-1-i], 1'b0, 1'b0);
        t1 = cyc_n;
        send_frame(8'h5A, 8'hC3, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("resync_t1", 32'(t1), 32'(t0 + W + 3));
        check("resync_err_count", 32'(err_cyc.size()), 32'd1);
        if (err_cyc.size() == 1) begin
            check("resync_err_cyc", 32'(err_cyc[0]), 32'(t1 + 1));
            check("resync_hold", 32'(err_dat[0]), 32'hA53C);
        end
        check("resync_valid_count", 32'(valid_cyc.size()), 32'd1);
        if (valid_cyc.size() == 1) begin
            check("resync_valid_cyc", 32'(valid_cyc[0]), 32'(t1 + L));
            check("resync_dat", 32'(valid_dat[0]), 32'h5AC3);
        end

`ifdef TDM_DEMUX2_PARITY_EN
        // Same data as a good frame but with the wrong parity bit.
        clear_logs();
        t0 = cyc_n;
        send_frame(8'hA5, 8'h3C, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("par_bad_err_count", 32'(err_cyc.size()), 32'd1);
        if (err_cyc.size() == 1) begin
            check("par_bad_err_cyc", 32'(err_cyc[0]), 32'(t0 + 2 * W + 1));
            check("par_bad_hold", 32'(err_dat[0]), 32'h5AC3);
        end
        check("par_bad_no_valid", 32'(valid_cyc.size()), 32'd0);
`endif

        // Reset at cycle 10 of a frame; the remaining bits carry no sync.
        clear_logs();
        w0 = 8'hC6;
        w1 = 8'h9D;
        for (int i = 0; i < 2 * W; i++) begin
            cyc((i < W) ? w0[W-1-i] : w1[2*W-1-i], (i == 0), (i == 10));
            if (i == 11) begin
                check("midreset_ch0", 32'(ch0_q), 32'h0);
                check("midreset_ch1", 32'(ch1_q), 32'h0);
                check("midreset_state", 32'(fsm_state), 32'h0);
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        check("midreset_no_valid", 32'(valid_cyc.size()), 32'd0);
        check("midreset_no_err", 32'(err_cyc.size()), 32'd0);
        check("midreset_ch0_after", 32'(ch0_q), 32'h0);

        check("valid_err_overlap", 32'(both_high), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
